ex_mem: RTL and testbench

// - EX->MEM pipeline register: latches execute-stage results each cycle and presents them to the memory stage.
// - Implements the stall/bubble/flush rules of the 6-stage stall vector.
// - Carries multi-cycle MADD/MSUB state (partial HI/LO product, step count) across stall cycles back to EX.

---
 rtl/ex_mem_pkg.sv | 60 ++++++
 rtl/ex_mem_if.sv | 47 ++++
 rtl/ex_mem.sv | 107 ++++++++++
 tb/tb_ex_mem.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared widths, constants and types for the EX->MEM pipeline register.
package ex_mem_pkg;

  localparam int REG_BUS_W    = 32;  // RegBus
  localparam int REG_ADDR_W   = 5;   // RegAddrBus
  localparam int DOUBLE_REG_W = 64;  // DoubleRegBus
  localparam int CNT_W        = 2;   // CntBus

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = 5'b0_0000;
  localparam logic [REG_BUS_W-1:0]  ZERO_WORD     = 32'h0000_0000;
  localparam logic                  WRITE_ENABLE  = 1'b1;
  localparam logic                  WRITE_DISABLE = 1'b0;
  localparam logic                  STOP          = 1'b1;
  localparam logic                  NO_STOP       = 1'b0;

  // What the slot does on the next rising edge.
  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } slot_action_e;

  // Contents of the EX->MEM slot as seen by the memory stage.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [REG_BUS_W-1:0]  wdata;
    logic [REG_BUS_W-1:0]  hi;
    logic [REG_BUS_W-1:0]  lo;
    logic                  whilo;
    logic                  valid;
  } mem_slot_t;

  localparam mem_slot_t EMPTY_SLOT = '{
    wd:    NOP_REG_ADDR,
    wreg:  WRITE_DISABLE,
    wdata: ZERO_WORD,
    hi:    ZERO_WORD,
    lo:    ZERO_WORD,
    whilo: WRITE_DISABLE,
    valid: 1'b0
  };

  // Priority flush > hold > bubble > advance. A stalled memory stage with a
  // running execute stage cannot occur, so it simply falls through to advance.
  function automatic slot_action_e decode_action(input logic flush,
                                                 input logic ex_stall,
                                                 input logic mem_stall);
    if (flush)
      return ACT_FLUSH;
    else if (ex_stall == STOP && mem_stall == STOP)
      return ACT_HOLD;
    else if (ex_stall == STOP && mem_stall == NO_STOP)
      return ACT_BUBBLE;
    else
      return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX->MEM bus: control (flush/stall), execute-stage results, memory-stage view
// and the MADD/MSUB state loop back to EX.
interface ex_mem_if
  import ex_mem_pkg::*;
#(
  parameter int STALL_W = 6
);

  logic                    flush;
  logic [STALL_W-1:0]      stall;

  logic [REG_ADDR_W-1:0]   ex_wd;
  logic                    ex_wreg;
  logic [REG_BUS_W-1:0]    ex_wdata;
  logic [REG_BUS_W-1:0]    ex_hi;
  logic [REG_BUS_W-1:0]    ex_lo;
  logic                    ex_whilo;
  logic [DOUBLE_REG_W-1:0] hilo_i;
  logic [CNT_W-1:0]        cnt_i;

  logic [REG_ADDR_W-1:0]   mem_wd;
  logic                    mem_wreg;
  logic [REG_BUS_W-1:0]    mem_wdata;
  logic [REG_BUS_W-1:0]    mem_hi;
  logic [REG_BUS_W-1:0]    mem_lo;
  logic                    mem_whilo;
  logic                    mem_valid;
  logic [DOUBLE_REG_W-1:0] hilo_o;
  logic [CNT_W-1:0]        cnt_o;

  // Pipeline/control side driving the register.
  modport master (
    output flush, stall, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
           hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_valid,
           hilo_o, cnt_o
  );

  // The pipeline register itself.
  modport slave (
    input  flush, stall, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
           hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_valid,
           hilo_o, cnt_o
  );

endinterface

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/bubble/flush handling and the
// MADD/MSUB partial-product loop back to EX.
// Optional macro EX_MEM_PERF_EN adds bubble_cnt/flush_cnt event counters.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic        clk,
  input  logic        rst,
  ex_mem_if.slave     bus
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
`endif
);

  slot_action_e            action;
  mem_slot_t               slot_q, slot_d;
  logic [DOUBLE_REG_W-1:0] hilo_q, hilo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  assign action = decode_action(bus.flush, bus.stall[EX_IDX], bus.stall[MEM_IDX]);

  // Next-state selection for the slot and the MADD/MSUB loop.
  always_comb begin
    // NOTE: defaults first so every path assigns every target and no latch is inferred.
    slot_d = slot_q;
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    unique case (action)
      ACT_FLUSH: begin
        slot_d = EMPTY_SLOT;
        hilo_d = '0;
        cnt_d  = '0;
      end
      ACT_HOLD: begin
        hilo_d = bus.hilo_i;
        cnt_d  = bus.cnt_i;
      end
      ACT_BUBBLE: begin
        slot_d = EMPTY_SLOT;
        hilo_d = bus.hilo_i;
        cnt_d  = bus.cnt_i;
      end
      ACT_ADVANCE: begin
        slot_d = '{
          wd:    bus.ex_wd,
          wreg:  bus.ex_wreg,
          wdata: bus.ex_wdata,
          hi:    bus.ex_hi,
          lo:    bus.ex_lo,
          whilo: bus.ex_whilo,
          valid: 1'b1
        };
        hilo_d = '0;
        cnt_d  = '0;
      end
    endcase
  end

  // Slot and loop registers; reset discards any in-flight MADD/MSUB state.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst) begin
      slot_q <= EMPTY_SLOT;
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.mem_wd    = slot_q.wd;
  assign bus.mem_wreg  = slot_q.wreg;
  assign bus.mem_wdata = slot_q.wdata;
  assign bus.mem_hi    = slot_q.hi;
  assign bus.mem_lo    = slot_q.lo;
  assign bus.mem_whilo = slot_q.whilo;
  assign bus.mem_valid = slot_q.valid;
  assign bus.hilo_o    = hilo_q;
  assign bus.cnt_o     = cnt_q;

`ifdef EX_MEM_PERF_EN
  logic [31:0] bubble_cnt_q, flush_cnt_q;

  // Free-running event counters, wrapping at 2^32, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (action == ACT_BUBBLE) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (action == ACT_FLUSH)  flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for ex_mem: reset, advance, hold, bubble with
// MADD state, illegal stall pattern, flush over hold, mid-MADD reset and,
// when EX_MEM_PERF_EN is defined, the event counters.
module tb_ex_mem;
  import ex_mem_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_mem_if #(.STALL_W(6)) bus ();

`ifdef EX_MEM_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;
`endif

  ex_mem #(.STALL_W(6), .EX_IDX(3), .MEM_IDX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef EX_MEM_PERF_EN
    ,
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    bus.ex_wd    = wd;
    bus.ex_wreg  = wreg;
    bus.ex_wdata = wdata;
    bus.ex_hi    = hi;
    bus.ex_lo    = lo;
    bus.ex_whilo = whilo;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".mem_wd"},    64'(bus.mem_wd),    64'd0);
    check({tag, ".mem_wreg"},  64'(bus.mem_wreg),  64'd0);
    check({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, ".mem_hi"},    64'(bus.mem_hi),    64'd0);
    check({tag, ".mem_lo"},    64'(bus.mem_lo),    64'd0);
    check({tag, ".mem_whilo"}, 64'(bus.mem_whilo), 64'd0);
    check({tag, ".mem_valid"}, 64'(bus.mem_valid), 64'd0);
    check({tag, ".hilo_o"},    bus.hilo_o,         64'd0);
    check({tag, ".cnt_o"},     64'(bus.cnt_o),     64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held from time zero with nonzero inputs present.
    rst        = 1'b0;
    bus.flush  = 1'b0;
    bus.stall  = 6'b000000;
    drive_ex(5'd9, 1'b1, 32'hFFFF_0000, 32'h1, 32'h2, 1'b1);
    bus.hilo_i = 64'h0123_4567_89AB_CDEF;
    bus.cnt_i  = 2'd3;
    #2;
    check_cleared("reset0");
    step();
    check_cleared("reset_edge");
    rst = 1'b1;

    // Advance: one-cycle latency, loop state cleared.
    drive_ex(5'd3, 1'b1, 32'h1234_5678, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1);
    bus.hilo_i = 64'h5555_5555_5555_5555;
    bus.cnt_i  = 2'd2;
    #2;
    check("adv.no_comb_path", 64'(bus.mem_wdata), 64'd0);
    step();
    check("adv.mem_wd",    64'(bus.mem_wd),    64'd3);
    check("adv.mem_wreg",  64'(bus.mem_wreg),  64'd1);
    check("adv.mem_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
    check("adv.mem_hi",    64'(bus.mem_hi),    64'hAAAA_0001);
    check("adv.mem_lo",    64'(bus.mem_lo),    64'hBBBB_0002);
    check("adv.mem_whilo", 64'(bus.mem_whilo), 64'd1);
    check("adv.mem_valid", 64'(bus.mem_valid), 64'd1);
    check("adv.hilo_o",    bus.hilo_o,         64'd0);
    check("adv.cnt_o",     64'(bus.cnt_o),     64'd0);

    // Hold for three cycles with changing EX data; loop state follows inputs.
    bus.stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      drive_ex(5'(10 + i), 1'b0, 32'hC0DE_0000 + 32'(i), 32'h0, 32'h0, 1'b0);
      bus.hilo_i = 64'h1000 + 64'(i);
      bus.cnt_i  = 2'(i + 1);
      step();
      check("hold.mem_wd",    64'(bus.mem_wd),    64'd3);
      check("hold.mem_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
      check("hold.mem_wreg",  64'(bus.mem_wreg),  64'd1);
      check("hold.mem_valid", 64'(bus.mem_valid), 64'd1);
      check("hold.hilo_o",    bus.hilo_o,         64'h1000 + 64'(i));
      check("hold.cnt_o",     64'(bus.cnt_o),     64'(i + 1));
    end

    // Bubble carrying MADD state back to EX.
    bus.stall  = 6'b001111;
    bus.hilo_i = 64'hDEAD_BEEF_0000_0001;
    bus.cnt_i  = 2'd1;
    drive_ex(5'd7, 1'b1, 32'h7777_7777, 32'h1, 32'h1, 1'b1);
    step();
    check("bub.mem_wreg",  64'(bus.mem_wreg),  64'd0);
    check("bub.mem_wd",    64'(bus.mem_wd),    64'd0);
    check("bub.mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("bub.mem_whilo", 64'(bus.mem_whilo), 64'd0);
    check("bub.mem_valid", 64'(bus.mem_valid), 64'd0);
    check("bub.hilo_o",    bus.hilo_o,         64'hDEAD_BEEF_0000_0001);
    check("bub.cnt_o",     64'(bus.cnt_o),     64'd1);

    // Release the stall: instruction advances, loop state cleared.
    bus.stall = 6'b000000;
    step();
    check("rel.mem_wd",    64'(bus.mem_wd),    64'd7);
    check("rel.mem_wdata", 64'(bus.mem_wdata), 64'h7777_7777);
    check("rel.mem_valid", 64'(bus.mem_valid), 64'd1);
    check("rel.hilo_o",    bus.hilo_o,         64'd0);
    check("rel.cnt_o",     64'(bus.cnt_o),     64'd0);

    // Illegal pattern (MEM stalled, EX running) behaves as advance.
    bus.stall = 6'b010000;
    drive_ex(5'd21, 1'b1, 32'h0BAD_F00D, 32'h0, 32'h0, 1'b0);
    step();
    check("ill.mem_wd",    64'(bus.mem_wd),    64'd21);
    check("ill.mem_wdata", 64'(bus.mem_wdata), 64'h0BAD_F00D);
    check("ill.mem_valid", 64'(bus.mem_valid), 64'd1);
    check("ill.hilo_o",    bus.hilo_o,         64'd0);

    // Flush wins over hold.
    bus.stall  = 6'b011111;
    bus.flush  = 1'b1;
    bus.hilo_i = 64'hFEED_FACE_CAFE_BABE;
    bus.cnt_i  = 2'd3;
    step();
    check_cleared("flush");
    bus.flush = 1'b0;

    // Mid-MADD reset: bubble loads state, then reset clears it without a clock.
    bus.stall  = 6'b001111;
    bus.hilo_i = 64'h0000_0001_0000_0002;
    bus.cnt_i  = 2'd2;
    step();
    check("madd.cnt_o", 64'(bus.cnt_o), 64'd2);
    #3;
    rst = 1'b0;
    #1;
    check_cleared("async_rst");
    step();
    rst = 1'b1;

    // Two bubbles then one flush from a clean reset.
    bus.stall = 6'b001111;
    step();
    step();
    bus.stall = 6'b000000;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("post.mem_valid", 64'(bus.mem_valid), 64'd0);
`ifdef EX_MEM_PERF_EN
    check("perf.bubble_cnt", 64'(bubble_cnt), 64'd2);
    check("perf.flush_cnt",  64'(flush_cnt),  64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
